// File: rtl/core_xbar_pkg.sv
// Shared types and constants for the core-to-memory crossbar:
// response-record layout, error data word and a saturating counter helper.
package core_xbar_pkg;

    localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;
    localparam int          SLV_IDX_W = 8;

    typedef enum logic {
        RSP_IDLE = 1'b0,
        RSP_RESP = 1'b1
    } rsp_state_e;

    // One outstanding response per master, returned the cycle after its grant.
    typedef struct packed {
        rsp_state_e           state;
        logic [SLV_IDX_W-1:0] slv;
        logic                 we;
        logic                 err;
    } rsp_rec_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/core_xbar_rr_arb.sv
// N-way round-robin arbiter: combinational one-hot grant, pointer moves to
// winner+1 on every grant and holds otherwise.
module core_xbar_rr_arb #(
    parameter int N = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_nxt;
    int            w_best;
    int            w_win;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_best = N;
        w_win  = 0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i] && (((i + N - int'(r_ptr)) % N) < w_best)) begin
                w_best = (i + N - int'(r_ptr)) % N;
                w_win  = i;
            end
        end
        gnt_o = '0;
        for (int i = 0; i < N; i++) begin
            gnt_o[i] = (w_best < N) && (w_win == i);
        end
        w_ptr_nxt = r_ptr;
        if (w_best < N) begin
            w_ptr_nxt = PW'((w_win + 1) % N);
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule

// File: rtl/core_mem_xbar.sv
// Core-to-memory crossbar: address decode into NB_SLAVE regions, per-region
// round-robin arbitration, single-cycle-latency responses and decode-error reporting.
module core_mem_xbar
    import core_xbar_pkg::*;
#(
    parameter int NB_MASTER      = 2,
    parameter int NB_SLAVE       = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter logic [NB_SLAVE-1:0][ADDR_WIDTH-1:0] START_ADDR =
        {32'h2100_0000, 32'h1001_0000, 32'h1000_0000},
    parameter logic [NB_SLAVE-1:0][ADDR_WIDTH-1:0] END_ADDR =
        {32'h2100_3FFF, 32'h1001_FFFF, 32'h1000_FFFF}
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic [NB_MASTER-1:0]                      m_req_i,
    output logic [NB_MASTER-1:0]                      m_gnt_o,
    output logic [NB_MASTER-1:0]                      m_rvalid_o,
    output logic [NB_MASTER-1:0]                      m_err_o,
    input  logic [NB_MASTER-1:0]                      m_we_i,
    input  logic [NB_MASTER-1:0][DATA_WIDTH/8-1:0]    m_be_i,
    input  logic [NB_MASTER-1:0][ADDR_WIDTH-1:0]      m_addr_i,
    input  logic [NB_MASTER-1:0][DATA_WIDTH-1:0]      m_wdata_i,
    output logic [NB_MASTER-1:0][DATA_WIDTH-1:0]      m_rdata_o,
    output logic [NB_SLAVE-1:0]                       s_req_o,
    output logic [NB_SLAVE-1:0]                       s_we_o,
    output logic [NB_SLAVE-1:0][DATA_WIDTH/8-1:0]     s_be_o,
    output logic [NB_SLAVE-1:0][MEM_ADDR_WIDTH-1:0]   s_addr_o,
    output logic [NB_SLAVE-1:0][DATA_WIDTH-1:0]       s_wdata_o,
    input  logic [NB_SLAVE-1:0][DATA_WIDTH-1:0]       s_rdata_i,
    output logic [15:0]                               err_count_o
);

    logic [NB_MASTER-1:0]                w_hit;
    logic [NB_MASTER-1:0]                w_miss;
    logic [NB_MASTER-1:0][SLV_IDX_W-1:0] w_sel;
    logic [NB_SLAVE-1:0][NB_MASTER-1:0]  w_slv_req;
    logic [NB_SLAVE-1:0][NB_MASTER-1:0]  w_slv_gnt;
    rsp_rec_t [NB_MASTER-1:0]            r_rsp;
    rsp_rec_t [NB_MASTER-1:0]            w_rsp_nxt;
    logic [15:0]                         r_err_cnt;
    logic [15:0]                         w_err_inc;

    // Descending scan so the lowest-index region wins on overlap.
    always_comb begin
        w_hit = '0;
        w_sel = '0;
        for (int m = 0; m < NB_MASTER; m++) begin
            for (int s = NB_SLAVE - 1; s >= 0; s--) begin
                if (m_addr_i[m] >= START_ADDR[s] && m_addr_i[m] <= END_ADDR[s]) begin
                    w_hit[m] = 1'b1;
                    w_sel[m] = SLV_IDX_W'(s);
                end
            end
        end
    end

    always_comb begin
        w_slv_req = '0;
        for (int s = 0; s < NB_SLAVE; s++) begin
            for (int m = 0; m < NB_MASTER; m++) begin
                w_slv_req[s][m] = rst_ni && m_req_i[m] && w_hit[m] && (w_sel[m] == SLV_IDX_W'(s));
            end
        end
    end

    for (genvar gs = 0; gs < NB_SLAVE; gs++) begin : g_arb
        core_xbar_rr_arb #(.N(NB_MASTER)) u_arb (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .req_i  (w_slv_req[gs]),
            .gnt_o  (w_slv_gnt[gs])
        );
    end

    // Decode misses are granted immediately; no region is touched.
    always_comb begin
        w_miss  = '0;
        m_gnt_o = '0;
        for (int m = 0; m < NB_MASTER; m++) begin
            w_miss[m]  = rst_ni && m_req_i[m] && !w_hit[m];
            m_gnt_o[m] = w_miss[m];
            for (int s = 0; s < NB_SLAVE; s++) begin
                m_gnt_o[m] = m_gnt_o[m] | w_slv_gnt[s][m];
            end
        end
    end

    always_comb begin
        s_req_o   = '0;
        s_we_o    = '0;
        s_be_o    = '0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        for (int s = 0; s < NB_SLAVE; s++) begin
            for (int m = 0; m < NB_MASTER; m++) begin
                if (w_slv_gnt[s][m]) begin
                    s_req_o[s]   = 1'b1;
                    s_we_o[s]    = m_we_i[m];
                    s_be_o[s]    = m_be_i[m];
                    s_addr_o[s]  = MEM_ADDR_WIDTH'(m_addr_i[m] - START_ADDR[s]);
                    s_wdata_o[s] = m_wdata_i[m];
                end
            end
        end
    end

    always_comb begin
        w_rsp_nxt = '0;
        w_err_inc = '0;
        for (int m = 0; m < NB_MASTER; m++) begin
            if (m_gnt_o[m]) begin
                w_rsp_nxt[m].state = RSP_RESP;
                w_rsp_nxt[m].slv   = w_sel[m];
                w_rsp_nxt[m].we    = m_we_i[m];
                w_rsp_nxt[m].err   = w_miss[m];
            end
            w_err_inc = w_err_inc + 16'(w_miss[m]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp     <= '0;
            r_err_cnt <= '0;
        end else begin
            r_rsp     <= w_rsp_nxt;
            r_err_cnt <= sat_add16(r_err_cnt, w_err_inc);
        end
    end

    always_comb begin
        m_rvalid_o = '0;
        m_err_o    = '0;
        m_rdata_o  = '0;
        for (int m = 0; m < NB_MASTER; m++) begin
            if (r_rsp[m].state == RSP_RESP) begin
                m_rvalid_o[m] = 1'b1;
                m_err_o[m]    = r_rsp[m].err;
                if (r_rsp[m].err) begin
                    m_rdata_o[m] = DATA_WIDTH'(ERR_DATA);
                end else if (!r_rsp[m].we) begin
                    for (int s = 0; s < NB_SLAVE; s++) begin
                        if (r_rsp[m].slv == SLV_IDX_W'(s)) begin
                            m_rdata_o[m] = s_rdata_i[s];
                        end
                    end
                end
            end
        end
    end

    assign err_count_o = r_err_cnt;

endmodule

// File: tb/tb_core_mem_xbar.sv
// Self-checking bench for core_mem_xbar: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a transaction model.
module tb_core_mem_xbar;

    localparam int NM  = 2;
    localparam int NS  = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MAW = 16;
    localparam int BW  = DW / 8;

    logic [31:0] st_a [NS] = '{32'h1000_0000, 32'h1001_0000, 32'h2100_0000};
    logic [31:0] en_a [NS] = '{32'h1000_FFFF, 32'h1001_FFFF, 32'h2100_3FFF};

    logic                    clk = 1'b0;
    logic                    rst_ni;
    logic [NM-1:0]           m_req, m_gnt, m_rvalid, m_err, m_we;
    logic [NM-1:0][BW-1:0]   m_be;
    logic [NM-1:0][AW-1:0]   m_addr;
    logic [NM-1:0][DW-1:0]   m_wdata, m_rdata;
    logic [NS-1:0]           s_req, s_we;
    logic [NS-1:0][BW-1:0]   s_be;
    logic [NS-1:0][MAW-1:0]  s_addr;
    logic [NS-1:0][DW-1:0]   s_wdata, s_rdata;
    logic [15:0]             err_count;

    core_mem_xbar #(
        .NB_MASTER(NM), .NB_SLAVE(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_ADDR_WIDTH(MAW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m_req_i(m_req), .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_err_o(m_err),
        .m_we_i(m_we), .m_be_i(m_be), .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_rdata_o(m_rdata),
        .s_req_o(s_req), .s_we_o(s_we), .s_be_o(s_be), .s_addr_o(s_addr),
        .s_wdata_o(s_wdata), .s_rdata_i(s_rdata), .err_count_o(err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] t=%0t actual=%h expected=%h", name, idx, $time, act, exp);
        end
    endtask

    // Transaction-level model: pointers, one pending response per master, error count.
    int ptr [NS];
    bit pv  [NM];
    bit pe  [NM];
    bit pw  [NM];
    int ps  [NM];
    int mcnt;

    function automatic int decode(input logic [31:0] a);
        for (int s = 0; s < NS; s++) begin
            if (a >= st_a[s] && a <= en_a[s]) return s;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++) ptr[s] = 0;
        for (int m = 0; m < NM; m++) begin
            pv[m] = 0; pe[m] = 0; pw[m] = 0; ps[m] = 0;
        end
        mcnt = 0;
    endtask

    always @(negedge clk) begin
        int          sel [NM];
        int          win [NS];
        bit          eg  [NM];
        logic [31:0] diff;
        logic [31:0] erd;
        if (!rst_ni) begin
            for (int m = 0; m < NM; m++) begin
                check("rst_gnt", m, 64'(m_gnt[m]), 64'd0);
                check("rst_rvalid", m, 64'(m_rvalid[m]), 64'd0);
                check("rst_err", m, 64'(m_err[m]), 64'd0);
                check("rst_rdata", m, 64'(m_rdata[m]), 64'd0);
            end
            for (int s = 0; s < NS; s++) begin
                check("rst_s_req", s, 64'(s_req[s]), 64'd0);
                check("rst_s_addr", s, 64'(s_addr[s]), 64'd0);
                check("rst_s_wdata", s, 64'(s_wdata[s]), 64'd0);
            end
            check("rst_err_count", 0, 64'(err_count), 64'd0);
            model_reset();
        end else begin
            for (int m = 0; m < NM; m++) sel[m] = decode(m_addr[m]);
            for (int s = 0; s < NS; s++) begin
                win[s] = -1;
                for (int k = 0; k < NM; k++) begin
                    int mm;
                    mm = (ptr[s] + k) % NM;
                    if (win[s] < 0 && m_req[mm] && sel[mm] == s) win[s] = mm;
                end
            end
            for (int m = 0; m < NM; m++) begin
                eg[m] = m_req[m] && (sel[m] < 0 || win[sel[m]] == m);
                check("gnt", m, 64'(m_gnt[m]), 64'(eg[m]));
                check("rvalid", m, 64'(m_rvalid[m]), 64'(pv[m]));
                check("err", m, 64'(m_err[m]), 64'(pv[m] && pe[m]));
                if (!pv[m] || (pw[m] && !pe[m])) erd = 32'h0;
                else if (pe[m]) erd = 32'hDEAD_BEEF;
                else erd = s_rdata[ps[m]];
                check("rdata", m, 64'(m_rdata[m]), 64'(erd));
            end
            for (int s = 0; s < NS; s++) begin
                if (win[s] >= 0) begin
                    diff = m_addr[win[s]] - st_a[s];
                    check("s_req", s, 64'(s_req[s]), 64'd1);
                    check("s_we", s, 64'(s_we[s]), 64'(m_we[win[s]]));
                    check("s_be", s, 64'(s_be[s]), 64'(m_be[win[s]]));
                    check("s_addr", s, 64'(s_addr[s]), 64'(diff[15:0]));
                    check("s_wdata", s, 64'(s_wdata[s]), 64'(m_wdata[win[s]]));
                end else begin
                    check("s_req", s, 64'(s_req[s]), 64'd0);
                    check("s_we", s, 64'(s_we[s]), 64'd0);
                    check("s_be", s, 64'(s_be[s]), 64'd0);
                    check("s_addr", s, 64'(s_addr[s]), 64'd0);
                    check("s_wdata", s, 64'(s_wdata[s]), 64'd0);
                end
            end
            check("err_count", 0, 64'(err_count), 64'(mcnt));
            // Advance the model to what the next clock edge commits.
            for (int s = 0; s < NS; s++) if (win[s] >= 0) ptr[s] = (win[s] + 1) % NM;
            for (int m = 0; m < NM; m++) begin
                pv[m] = eg[m];
                pe[m] = eg[m] && sel[m] < 0;
                pw[m] = m_we[m];
                ps[m] = (sel[m] < 0) ? 0 : sel[m];
                if (pe[m] && mcnt < 65535) mcnt++;
            end
        end
    end

    task automatic drive_idle();
        m_req = '0; m_we = '0; m_be = '0; m_addr = '0; m_wdata = '0;
    endtask

    task automatic cyc_begin();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_mid();
        @(negedge clk);
        #1;
    endtask

    task automatic rd(input int m, input logic [31:0] a);
        m_req[m] = 1'b1; m_we[m] = 1'b0; m_be[m] = '1; m_addr[m] = a; m_wdata[m] = '0;
    endtask

    function automatic logic [31:0] rand_addr();
        int          r;
        int          s;
        logic [31:0] span;
        r    = $urandom_range(7);
        s    = $urandom_range(NS - 1);
        span = en_a[s] - st_a[s] + 32'd1;
        case (r)
            0, 1, 2: return st_a[s] + ($urandom % span);
            3:       return st_a[s];
            4:       return en_a[s];
            5:       return en_a[s] + 32'd1;
            6:       return st_a[s] - 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_ni = 1'b0;
        drive_idle();
        s_rdata = '0;
        cyc_mid();
        check("lit_reset_rvalid", 0, 64'(m_rvalid), 64'd0);
        check("lit_reset_err_count", 0, 64'(err_count), 64'd0);

        // Single read on region 0.
        cyc_begin();
        rst_ni = 1'b1;
        s_rdata[0] = 32'hA5A5_0001;
        s_rdata[1] = 32'h1111_2222;
        s_rdata[2] = 32'hFFFF_FFFF;
        rd(0, 32'h1000_0010);
        cyc_mid();
        check("lit_rd_gnt", 0, 64'(m_gnt[0]), 64'd1);
        check("lit_rd_sreq", 0, 64'(s_req[0]), 64'd1);
        check("lit_rd_saddr", 0, 64'(s_addr[0]), 64'h0010);
        cyc_begin();
        drive_idle();
        cyc_mid();
        check("lit_rd_rvalid", 0, 64'(m_rvalid[0]), 64'd1);
        check("lit_rd_rdata", 0, 64'(m_rdata[0]), 64'hA5A5_0001);

        // Contention on region 1: grants alternate M0, M1, M0, M1.
        for (int c = 0; c < 4; c++) begin
            cyc_begin();
            drive_idle();
            rd(0, 32'h1001_0000);
            rd(1, 32'h1001_0000);
            cyc_mid();
            check("lit_rr_gnt0", c, 64'(m_gnt[0]), 64'((c % 2) == 0));
            check("lit_rr_gnt1", c, 64'(m_gnt[1]), 64'((c % 2) == 1));
            if (c > 0) begin
                check("lit_rr_rvalid", c, 64'(m_rvalid), (c % 2) == 1 ? 64'b01 : 64'b10);
                check("lit_rr_rdata", c, 64'(m_rdata[(c - 1) % 2]), 64'h1111_2222);
            end
        end
        cyc_begin();
        drive_idle();
        cyc_mid();
        check("lit_rr_last_rvalid", 0, 64'(m_rvalid), 64'b10);

        // Parallel grants to different regions.
        cyc_begin();
        rd(0, 32'h1000_0000);
        rd(1, 32'h2100_0004);
        cyc_mid();
        check("lit_par_gnt", 0, 64'(m_gnt), 64'b11);
        check("lit_par_saddr2", 2, 64'(s_addr[2]), 64'h0004);
        check("lit_par_sreq", 0, 64'(s_req), 64'b101);

        // Byte-masked write.
        cyc_begin();
        drive_idle();
        m_req[0] = 1'b1; m_we[0] = 1'b1; m_be[0] = 4'b0011;
        m_addr[0] = 32'h2100_0000; m_wdata[0] = 32'h1234_5678;
        cyc_mid();
        check("lit_wr_swe", 2, 64'(s_we[2]), 64'd1);
        check("lit_wr_sbe", 2, 64'(s_be[2]), 64'b0011);
        check("lit_wr_swdata", 2, 64'(s_wdata[2]), 64'h1234_5678);
        cyc_begin();
        drive_idle();
        cyc_mid();
        check("lit_wr_rvalid", 0, 64'(m_rvalid[0]), 64'd1);
        check("lit_wr_rdata", 0, 64'(m_rdata[0]), 64'd0);

        // Decode miss.
        cyc_begin();
        rd(1, 32'h3000_0000);
        cyc_mid();
        check("lit_miss_gnt", 1, 64'(m_gnt[1]), 64'd1);
        check("lit_miss_sreq", 0, 64'(s_req), 64'd0);
        cyc_begin();
        drive_idle();
        cyc_mid();
        check("lit_miss_rvalid", 1, 64'(m_rvalid[1]), 64'd1);
        check("lit_miss_err", 1, 64'(m_err[1]), 64'd1);
        check("lit_miss_rdata", 1, 64'(m_rdata[1]), 64'hDEAD_BEEF);
        check("lit_miss_count", 0, 64'(err_count), 64'd1);

        // Reset between grant and response; pointers must restart at 0.
        cyc_begin();
        rd(0, 32'h1000_0000);
        rd(1, 32'h1000_0000);
        cyc_mid();
        check("lit_pre_rst_gnt", 0, 64'(m_gnt), 64'b10);
        #1 rst_ni = 1'b0;
        cyc_begin();
        cyc_mid();
        check("lit_rst_gnt", 0, 64'(m_gnt), 64'd0);
        check("lit_rst_rvalid", 0, 64'(m_rvalid), 64'd0);
        check("lit_rst_sreq", 0, 64'(s_req), 64'd0);
        cyc_begin();
        rst_ni = 1'b1;
        drive_idle();
        cyc_mid();
        check("lit_post_rst_rvalid", 0, 64'(m_rvalid), 64'd0);
        cyc_begin();
        rd(0, 32'h1000_0000);
        rd(1, 32'h1000_0000);
        cyc_mid();
        check("lit_ptr0_gnt", 0, 64'(m_gnt), 64'b01);
        cyc_begin();
        rd(0, 32'h2100_0000);
        rd(1, 32'h2100_0000);
        cyc_mid();
        check("lit_ptr2_gnt", 0, 64'(m_gnt), 64'b01);

        // Randomized traffic, including region boundaries and a reset pulse.
        for (int i = 0; i < 400; i++) begin
            cyc_begin();
            if (i == 200) rst_ni = 1'b0;
            if (i == 202) rst_ni = 1'b1;
            for (int m = 0; m < NM; m++) begin
                m_req[m]   = ($urandom_range(9) < 7);
                m_we[m]    = $urandom_range(1);
                m_be[m]    = BW'($urandom);
                m_addr[m]  = rand_addr();
                m_wdata[m] = $urandom;
            end
            for (int s = 0; s < NS; s++) s_rdata[s] = $urandom;
        end

        // Error counter saturation.
        cyc_begin();
        drive_idle();
        for (int i = 0; i < 65540; i++) begin
            rd(1, 32'h3000_0000);
            cyc_begin();
        end
        drive_idle();
        cyc_mid();
        check("lit_sat_count", 0, 64'(err_count), 64'hFFFF);
        cyc_begin();
        cyc_mid();
        check("lit_sat_hold", 0, 64'(err_count), 64'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_mem_xbar.md
CORE_MEM_XBAR -- requirements
Module: core_mem_xbar

Interface
REQ-001 SHALL have parameter NB_MASTER, default 2, number of core-side request ports.
REQ-002 SHALL have parameter NB_SLAVE, default 3, number of memory-side regions.
REQ-003 SHALL have parameters ADDR_WIDTH 32, DATA_WIDTH 32, MEM_ADDR_WIDTH 16: bus address, data and per-region memory address widths.
REQ-004 SHALL have parameters START_ADDR and END_ADDR, each NB_SLAVE x ADDR_WIDTH, giving the inclusive per-region address bounds.
REQ-005 SHALL have ports clk_i (in, 1, clock) and rst_ni (in, 1, reset); one clock; reset is asynchronous and active-low.
REQ-006 SHALL have master ports, per master: m_req_i in 1, m_gnt_o out 1, m_rvalid_o out 1, m_err_o out 1, m_we_i in 1, m_be_i in DATA_WIDTH/8, m_addr_i in ADDR_WIDTH, m_wdata_i in DATA_WIDTH, m_rdata_o out DATA_WIDTH.
REQ-007 SHALL have slave ports, per slave: s_req_o out 1, s_we_o out 1, s_be_o out DATA_WIDTH/8, s_addr_o out MEM_ADDR_WIDTH, s_wdata_o out DATA_WIDTH, s_rdata_i in DATA_WIDTH.
REQ-008 SHALL have err_count_o, out, 16 bits: the number of decode errors seen.

Function
REQ-009 SHALL decode a hit on region i when START_ADDR[i] <= m_addr_i <= END_ADDR[i]; on overlapping regions the lowest index SHALL win.
REQ-010 SHALL drive s_addr_o = (m_addr_i - START_ADDR[i]) truncated to MEM_ADDR_WIDTH.
REQ-011 SHALL arbitrate each slave round-robin among the masters targeting it; m_gnt_o SHALL be combinational in the same cycle as m_req_i.
REQ-012 SHALL advance the round-robin pointer of a slave to (winner+1) mod NB_MASTER on each grant; a slave with no grant SHALL hold its pointer.
REQ-013 SHALL grant masters targeting different slaves in the same cycle, independently of each other.
REQ-014 SHALL assume slaves have a fixed read latency of one cycle; s_req_o is asserted only in the grant cycle.
REQ-015 SHALL assert m_rvalid_o exactly one cycle after each accepted transfer (m_req_i & m_gnt_o), for reads and writes.
REQ-016 SHALL return s_rdata_i of the granted slave on m_rdata_o for reads, and zero for writes.
REQ-017 SHALL hold a per-master response register (states IDLE/RESP) recording valid, slave index, we and err; a new grant in a RESP cycle reloads the register, giving back-to-back throughput of one transfer per cycle.
REQ-018 SHALL, on a decode miss, grant in the same cycle with no s_req_o, then the next cycle assert m_rvalid_o with m_err_o=1 and m_rdata_o=ERR_DATA.
REQ-019 SHALL increment err_count_o on each decode error and saturate it at 16'hFFFF.
REQ-020 SHALL drive all s_* outputs to zero when the slave is idle, and m_rdata_o/m_err_o to zero when m_rvalid_o=0.

Reset
REQ-021 SHALL, while rst_ni=0, clear all m_gnt_o, m_rvalid_o, m_err_o, m_rdata_o, s_* outputs, round-robin pointers (to 0), response registers and err_count_o.
REQ-022 SHALL drop any response pending at reset assertion; no m_rvalid_o SHALL follow reset release without a new grant.

Structure
REQ-023 SHALL place the response-record typedef and the ERR_DATA constant (32'hDEAD_BEEF) in the shared package core_xbar_pkg.
REQ-024 SHALL instantiate one sub-module, core_xbar_rr_arb (NB_MASTER-way round-robin arbiter with pointer register), per slave.

Verification
Setup: NB_MASTER=2, NB_SLAVE=3, START {1000_0000, 1001_0000, 2100_0000}, END {1000_FFFF, 1001_FFFF, 2100_3FFF}.
REQ-025 SHALL cover: M0 reads 0x1000_0010 with s_rdata_i[0]=0xA5A5_0001 -> s_req_o[0]=1, s_addr_o=0x0010 and m_gnt_o[0] in the same cycle; the next cycle gives m_rvalid_o[0]=1 with m_rdata_o=0xA5A5_0001.
REQ-026 SHALL cover: both masters request 0x1001_0000 continuously for 4 cycles -> grants alternate M0, M1, M0, M1, each followed by rvalid one cycle later.
REQ-027 SHALL cover: M0 requests 0x1000_0000 and M1 requests 0x2100_0004 in the same cycle -> both granted that cycle, with s_addr_o[2]=0x0004.
REQ-028 SHALL cover: M1 reads 0x3000_0000 -> gnt and no s_req_o; the next cycle gives rvalid, err=1, rdata=0xDEAD_BEEF and err_count_o=1; after 65540 errors err_count_o=0xFFFF.
REQ-029 SHALL cover: M0 writes 0x2100_0000 with be=4'b0011 and wdata=0x1234_5678 -> s_we_o[2]=1, s_be_o=0011, s_wdata_o matching; the next cycle gives rvalid with rdata=0.
REQ-030 SHALL cover: rst_ni falls between grant and rvalid -> no m_rvalid_o, all outputs zero, round-robin pointers 0 after release.
